// File: rtl/shift_reg_piso.sv
// Parallel-in / serial-out shift register with a two-state IDLE/SHIFT FSM.
// Words can be loaded back-to-back on the last-bit cycle, so the serial stream has no gaps.
module shift_reg_piso #(
  parameter int size      = 8,
  parameter bit msb_first = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [size-1:0] datain,
  output logic            ready,
  output logic            dataout,
  output logic            valid,
  output logic            done
);

  localparam int CNT_W = $clog2(size + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(size);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [size-1:0]   sreg_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic              last;
  logic              accept;

  function automatic logic [size-1:0] shift_one(input logic [size-1:0] v);
    if (msb_first) return {v[size-2:0], 1'b0};
    else           return {1'b0, v[size-1:1]};
  endfunction

  assign last   = (state == SHIFT) && (cnt_p0 == CNT_ONE);
  assign accept = load && ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (last && !load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only; load/datain never reach them combinationally.
  always_comb begin
    ready   = (state == IDLE) || last;
    valid   = (state == SHIFT);
    done    = last;
    dataout = 1'b0;
    if (state == SHIFT) dataout = msb_first ? sreg_p0[size-1] : sreg_p0[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg_p0 <= '0;
      cnt_p0  <= '0;
    end else if (accept) begin
      sreg_p0 <= datain;
      cnt_p0  <= CNT_FULL;
    end else if (state == SHIFT) begin
      if (last) begin
        sreg_p0 <= '0;
        cnt_p0  <= '0;
      end else begin
        sreg_p0 <= shift_one(sreg_p0);
        cnt_p0  <= cnt_p0 - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_piso.sv
// Scoreboard bench for shift_reg_piso: three instances (8-bit LSB-first, 8-bit MSB-first, 4-bit LSB-first).
// Stimulus pushes hand-computed serial bits; per-instance monitors pop and compare on every valid cycle.
module tb_shift_reg_piso;

  typedef struct packed {
    logic d;
    logic dn;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  logic       load_a, load_b, load_c;
  logic [7:0] datain_a, datain_b;
  logic [3:0] datain_c;
  logic       ready_a, dataout_a, valid_a, done_a;
  logic       ready_b, dataout_b, valid_b, done_b;
  logic       ready_c, dataout_c, valid_c, done_c;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t e_a, e_b, e_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_reg_piso #(.size(8), .msb_first(1'b0)) dut_a (
    .clk(clk), .reset(reset), .load(load_a), .datain(datain_a),
    .ready(ready_a), .dataout(dataout_a), .valid(valid_a), .done(done_a)
  );

  shift_reg_piso #(.size(8), .msb_first(1'b1)) dut_b (
    .clk(clk), .reset(reset), .load(load_b), .datain(datain_b),
    .ready(ready_b), .dataout(dataout_b), .valid(valid_b), .done(done_b)
  );

  shift_reg_piso #(.size(4), .msb_first(1'b0)) dut_c (
    .clk(clk), .reset(reset), .load(load_c), .datain(datain_c),
    .ready(ready_c), .dataout(dataout_c), .valid(valid_c), .done(done_c)
  );

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  // bits are listed in emission order, first bit in the literal's MSB
  task automatic push_a(input logic [7:0] bits);
    for (int i = 7; i >= 0; i--) q_a.push_back('{d: bits[i], dn: (i == 0)});
  endtask

  task automatic push_b(input logic [7:0] bits);
    for (int i = 7; i >= 0; i--) q_b.push_back('{d: bits[i], dn: (i == 0)});
  endtask

  task automatic push_c(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) q_c.push_back('{d: bits[i], dn: (i == 0)});
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && valid_a === 1'b1) begin
      if (q_a.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected_valid: actual valid=1 required no pending bits");
      end else begin
        e_a = q_a.pop_front();
        check_bit("a_dataout", dataout_a, e_a.d);
        check_bit("a_done", done_a, e_a.dn);
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1 && valid_b === 1'b1) begin
      if (q_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected_valid: actual valid=1 required no pending bits");
      end else begin
        e_b = q_b.pop_front();
        check_bit("b_dataout", dataout_b, e_b.d);
        check_bit("b_done", done_b, e_b.dn);
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1 && valid_c === 1'b1) begin
      if (q_c.size() == 0) begin
        tests++; fails++;
        $display("FAIL c_unexpected_valid: actual valid=1 required no pending bits");
      end else begin
        e_c = q_c.pop_front();
        check_bit("c_dataout", dataout_c, e_c.d);
        check_bit("c_done", done_c, e_c.dn);
      end
    end
  end

  initial begin
    reset = 1'b0;
    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
    datain_a = 8'h00; datain_b = 8'h00; datain_c = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_ready", ready_a, 1'b1);
    check_bit("rst_valid", valid_a, 1'b0);
    check_bit("rst_done", done_a, 1'b0);
    check_bit("rst_dataout", dataout_a, 1'b0);
    check_bit("rst_ready_b", ready_b, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 8'h55 LSB-first
    load_a = 1'b1; datain_a = 8'h55; push_a(8'b10101010);
    @(posedge clk); #1;
    load_a = 1'b0; datain_a = 8'h00;
    check_bit("t55_ready_busy", ready_a, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    check_bit("t55_ready_last", ready_a, 1'b1);
    @(posedge clk); #1;
    check_bit("t55_idle_ready", ready_a, 1'b1);
    check_bit("t55_idle_valid", valid_a, 1'b0);

    // 8'hA3 MSB-first
    load_b = 1'b1; datain_b = 8'hA3; push_b(8'b10100011);
    @(posedge clk); #1;
    load_b = 1'b0; datain_b = 8'h00;
    repeat (8) @(posedge clk);
    #1;
    check_bit("tA3_idle_ready", ready_b, 1'b1);
    check_bit("tA3_idle_valid", valid_b, 1'b0);

    // back-to-back 8'h0F then 8'hF0
    load_a = 1'b1; datain_a = 8'h0F; push_a(8'b11110000);
    @(posedge clk); #1;
    load_a = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check_bit("b2b_ready_on_done", ready_a, 1'b1);
    load_a = 1'b1; datain_a = 8'hF0; push_a(8'b00001111);
    @(posedge clk); #1;
    load_a = 1'b0; datain_a = 8'h00;
    check_bit("b2b_no_gap", valid_a, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check_bit("b2b_idle_valid", valid_a, 1'b0);

    // load during word is ignored
    load_a = 1'b1; datain_a = 8'hFF; push_a(8'b11111111);
    @(posedge clk); #1;
    load_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("ign_ready_busy", ready_a, 1'b0);
    load_a = 1'b1; datain_a = 8'h00;
    @(posedge clk); #1;
    load_a = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_bit("ign_idle_valid", valid_a, 1'b0);

    // asynchronous reset mid-word
    load_a = 1'b1; datain_a = 8'hFF; push_a(8'b11111111);
    @(posedge clk); #1;
    load_a = 1'b0; datain_a = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    q_a.delete();
    #1;
    check_bit("arst_ready", ready_a, 1'b1);
    check_bit("arst_valid", valid_a, 1'b0);
    check_bit("arst_done", done_a, 1'b0);
    check_bit("arst_dataout", dataout_a, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_bit("arst_no_resume", valid_a, 1'b0);
    load_a = 1'b1; datain_a = 8'h01; push_a(8'b10000000);
    @(posedge clk); #1;
    load_a = 1'b0; datain_a = 8'h00;
    repeat (8) @(posedge clk);
    #1;

    // size=4, load held with 4'h9 for 12 cycles
    load_c = 1'b1; datain_c = 4'h9;
    push_c(4'b1001); push_c(4'b1001); push_c(4'b1001);
    repeat (12) @(posedge clk);
    #1;
    load_c = 1'b0; datain_c = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("held_idle_valid", valid_c, 1'b0);
    check_bit("held_idle_ready", ready_c, 1'b1);

    for (int i = 0; i < 50; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0 && q_c.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check_bit("a_drained", q_a.size() == 0, 1'b1);
    check_bit("b_drained", q_b.size() == 0, 1'b1);
    check_bit("c_drained", q_c.size() == 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_reg_piso.md
SHIFT_REG_PISO -- requirements
Module: shift_reg_piso

Interface
REQ-001 SHALL have parameter size, default 8: parallel word width in bits; legal range 2..64.
REQ-002 SHALL have parameter msb_first, default 0: 0 shifts bit 0 out first, 1 shifts bit size-1 out first.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port load  input  1: request to capture datain; accepted only when load=1 and ready=1 at a rising edge.
REQ-006 SHALL have port datain  input  size: parallel word to serialise.
REQ-007 SHALL have port ready  output  1: block can accept a word this cycle.
REQ-008 SHALL have port dataout  output  1: current serial bit.
REQ-009 SHALL have port valid  output  1: dataout carries a payload bit this cycle.
REQ-010 SHALL have port done  output  1: current cycle carries the last bit of a word.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-012 SHALL hold a size-bit shift register and a bit counter of width clog2(size+1).
REQ-013 In IDLE: ready=1, valid=0, done=0, dataout=0.
REQ-014 On a rising edge with load=1 and ready=1: capture datain into the shift register, set the counter to size, enter SHIFT.
REQ-015 In SHIFT: valid=1; dataout = shift register bit 0 (msb_first=0) or bit size-1 (msb_first=1).
REQ-016 Latency: the first bit appears in the cycle immediately after the accepting edge; bit k appears k+1 cycles after it.
REQ-017 On each rising edge in SHIFT with counter>1: shift one position toward the output end and decrement the counter. The vacated bit fills with 0.
REQ-018 When counter==1 (last bit): done=1 and ready=1, both combinational from state.
REQ-019 On an edge with counter==1 and load=1: reload from datain, set the counter to size, and stay in SHIFT, giving gap-free back-to-back words.
REQ-020 On an edge with counter==1 and load=0: enter IDLE, clear the shift register and the counter.
REQ-021 In SHIFT with counter>1: ready=0; load SHALL be ignored, and datain changes SHALL NOT affect the word in flight.
REQ-022 Held load in IDLE SHALL be accepted once per word; with load held high, the block streams continuously.
REQ-023 Exactly size valid cycles per accepted word; done SHALL be high for exactly one cycle per word.
REQ-024 dataout, valid and done SHALL be glitch-free functions of registered state only; they SHALL NOT depend combinationally on load or datain.

Reset
REQ-025 reset=0 SHALL immediately and asynchronously force IDLE, clear the shift register to 0 and the counter to 0, giving ready=1, valid=0, done=0, dataout=0.
REQ-026 Reset asserted mid-word SHALL abort the word; remaining bits SHALL NOT be emitted after reset release.
REQ-027 After reset deasserts, the first rising edge with load=1 SHALL be accepted normally.

Verification
REQ-028 size=8, msb_first=0, load 8'h55 -> next 8 cycles dataout = 1,0,1,0,1,0,1,0; valid=1 throughout; done only on the 8th cycle; then IDLE with ready=1.
REQ-029 size=8, msb_first=1, load 8'hA3 -> dataout = 1,0,1,0,0,0,1,1; done on the 8th bit.
REQ-030 Back-to-back: load 8'h0F, then load=1 with 8'hF0 on the done cycle -> 16 consecutive valid cycles, LSB-first bits 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1; done pulses on cycles 8 and 16.
REQ-031 Load 8'hFF, then assert load with 8'h00 on bit 3 -> ignored (ready=0); all 8 output bits = 1.
REQ-032 Load 8'hFF, assert reset low during bit 3 -> outputs go to 0 and ready goes to 1 before the next edge; no further valid after release; a fresh load of 8'h01 emits 1,0,0,0,0,0,0,0.
REQ-033 size=4, load held high with datain fixed at 4'h9 for 12 cycles -> continuous pattern 1,0,0,1 repeated three times; done every 4th cycle.
